// File: rtl/countdown_ctrl.sv
// Countdown-timer controller for the hh:mm:ss timer datapath.
//
// Sequences set / run / pause / alarm. Button inputs are debounced, synchronized
// single-cycle pulses; tick_1hz is a one-cycle pulse per second. All outputs are
// registered (one-cycle latency from the causing input).
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active-low
//   tick_1hz     one-cycle pulse, once per second
//   btn_start    start / pause / resume / alarm acknowledge
//   btn_clear    abort and zero the time
//   btn_inc_min  minute +1 while setting (IDLE or PAUSE)
//   btn_inc_hour hour +1 while setting (IDLE or PAUSE)
//   r_hour       remaining hours   (0..HOUR_MAX)
//   r_minute     remaining minutes (0..59)
//   r_second     remaining seconds (0..59)
//   running      high in RUN
//   alarm        high in ALARM
//   expired      one-cycle pulse on entry to ALARM
module countdown_ctrl #(
  parameter int unsigned ALARM_SECS = 10,  // 1..63
  parameter int unsigned HOUR_MAX   = 23   // 1..31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_inc_min,
  input  logic       btn_inc_hour,
  output logic [4:0] r_hour,
  output logic [5:0] r_minute,
  output logic [5:0] r_second,
  output logic       running,
  output logic       alarm,
  output logic       expired
);

  localparam logic [4:0] HourMax   = 5'(HOUR_MAX);
  localparam logic [5:0] AlarmSecs = 6'(ALARM_SECS);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} state_e;

  state_e     state_q, state_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] alarm_cnt_q, alarm_cnt_d;
  logic       expired_q, expired_d;

  logic       time_nz;
  logic       last_sec;
  logic [5:0] min_inc;
  logic [4:0] hour_inc;

  assign time_nz  = (hour_q != '0) || (min_q != '0) || (sec_q != '0);
  assign last_sec = (hour_q == '0) && (min_q == '0) && (sec_q == 6'd1);
  assign min_inc  = (min_q == 6'd59) ? '0 : min_q + 6'd1;
  // >= keeps the wrap safe even if the register somehow exceeds HourMax
  assign hour_inc = (hour_q >= HourMax) ? '0 : hour_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    alarm_cnt_d = alarm_cnt_q;
    expired_d   = 1'b0;

    if (btn_clear) begin
      state_d     = StIdle;
      hour_d      = '0;
      min_d       = '0;
      sec_d       = '0;
      alarm_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (btn_start) begin
            // Start with a zero time is a no-op; it still masks inc buttons.
            if (time_nz) state_d = StRun;
          end else begin
            if (btn_inc_min)  min_d  = min_inc;
            if (btn_inc_hour) hour_d = hour_inc;
          end
        end

        StRun: begin
          if (btn_start) begin
            state_d = StPause;
          end else if (tick_1hz) begin
            if (last_sec || !time_nz) begin
              // Zero-time guard prevents an underflow wrap should RUN ever hold 0.
              state_d     = StAlarm;
              hour_d      = '0;
              min_d       = '0;
              sec_d       = '0;
              alarm_cnt_d = AlarmSecs;
              expired_d   = 1'b1;
            end else if (sec_q != '0) begin
              sec_d = sec_q - 6'd1;
            end else if (min_q != '0) begin
              sec_d = 6'd59;
              min_d = min_q - 6'd1;
            end else begin
              sec_d  = 6'd59;
              min_d  = 6'd59;
              hour_d = hour_q - 5'd1;
            end
          end
        end

        StPause: begin
          if (btn_start) begin
            state_d = time_nz ? StRun : StIdle;
          end else begin
            if (btn_inc_min)  min_d  = min_inc;
            if (btn_inc_hour) hour_d = hour_inc;
          end
        end

        StAlarm: begin
          if (btn_start) begin
            state_d     = StIdle;
            alarm_cnt_d = '0;
          end else if (tick_1hz) begin
            if (alarm_cnt_q <= 6'd1) begin
              state_d     = StIdle;
              alarm_cnt_d = '0;
            end else begin
              alarm_cnt_d = alarm_cnt_q - 6'd1;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      alarm_cnt_q <= '0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      alarm_cnt_q <= alarm_cnt_d;
      expired_q   <= expired_d;
    end
  end

  assign r_hour   = hour_q;
  assign r_minute = min_q;
  assign r_second = sec_q;
  assign running  = (state_q == StRun);
  assign alarm    = (state_q == StAlarm);
  assign expired  = expired_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed stimulus pushes hand-computed
// expected outputs into a scoreboard queue; a monitor on the falling edge pops and
// compares them against the DUT.
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_inc_min = 1'b0;
  logic       btn_inc_hour = 1'b0;
  logic [4:0] r_hour;
  logic [5:0] r_minute;
  logic [5:0] r_second;
  logic       running;
  logic       alarm;
  logic       expired;

  countdown_ctrl #(
    .ALARM_SECS(10),
    .HOUR_MAX  (23)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .btn_start   (btn_start),
    .btn_clear   (btn_clear),
    .btn_inc_min (btn_inc_min),
    .btn_inc_hour(btn_inc_hour),
    .r_hour      (r_hour),
    .r_minute    (r_minute),
    .r_second    (r_second),
    .running     (running),
    .alarm       (alarm),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    stamp;
    string name;
    int    h;
    int    m;
    int    s;
    logic  run;
    logic  alm;
    logic  exp;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation stamped for the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].stamp <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (int'(r_hour) == e.h && int'(r_minute) == e.m && int'(r_second) == e.s &&
          running == e.run && alarm == e.alm && expired == e.exp) begin
        passes++;
      end else begin
        $display("FAIL %s: got %0d:%0d:%0d run=%0b alarm=%0b expired=%0b, want %0d:%0d:%0d run=%0b alarm=%0b expired=%0b",
                 e.name, r_hour, r_minute, r_second, running, alarm, expired,
                 e.h, e.m, e.s, e.run, e.alm, e.exp);
      end
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic drive(input logic rn, input logic st, input logic cl, input logic im,
                       input logic ih, input logic tk);
    rst_n        = rn;
    btn_start    = st;
    btn_clear    = cl;
    btn_inc_min  = im;
    btn_inc_hour = ih;
    tick_1hz     = tk;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    btn_start    = 1'b0;
    btn_clear    = 1'b0;
    btn_inc_min  = 1'b0;
    btn_inc_hour = 1'b0;
    tick_1hz     = 1'b0;
  endtask

  task automatic start();   drive(1, 1, 0, 0, 0, 0); endtask
  task automatic clear();   drive(1, 0, 1, 0, 0, 0); endtask
  task automatic inc_min(); drive(1, 0, 0, 1, 0, 0); endtask
  task automatic inc_hr();  drive(1, 0, 0, 0, 1, 0); endtask
  task automatic tick();    drive(1, 0, 0, 0, 0, 1); endtask
  task automatic idle();    drive(1, 0, 0, 0, 0, 0); endtask

  task automatic expect_out(input string nm, input int h, input int m, input int s,
                            input logic run, input logic alm, input logic exp);
    exp_t e;
    e.stamp = cyc;
    e.name  = nm;
    e.h     = h;
    e.m     = m;
    e.s     = s;
    e.run   = run;
    e.alm   = alm;
    e.exp   = exp;
    sb_q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with tick toggling.
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    start();
    expect_out("start_zero_idle", 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("tick_idle_ignored", 0, 0, 0, 0, 0, 0);

    // Set and wrap.
    for (int i = 0; i < 61; i++) begin
      inc_min();
      if (i == 58) expect_out("min_59", 0, 59, 0, 0, 0, 0);
      if (i == 59) expect_out("min_wrap_0", 0, 0, 0, 0, 0, 0);
    end
    expect_out("min_61", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) begin
      inc_hr();
      if (i == 22) expect_out("hour_23", 23, 1, 0, 0, 0, 0);
      if (i == 23) expect_out("hour_wrap_0", 0, 1, 0, 0, 0, 0);
    end
    expect_out("hour_25", 1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 0);
    expect_out("inc_both", 2, 2, 0, 0, 0, 0);
    clear();
    expect_out("clear_idle", 0, 0, 0, 0, 0, 0);

    // Borrow chain from 01:00:00 and first expiry.
    inc_hr();
    start();
    expect_out("run_1h", 1, 0, 0, 1, 0, 0);
    tick();
    expect_out("borrow_chain", 0, 59, 59, 1, 0, 0);
    for (int i = 0; i < 3598; i++) tick();
    expect_out("one_sec_left", 0, 0, 1, 1, 0, 0);
    tick();
    expect_out("expiry", 0, 0, 0, 0, 1, 1);
    inc_min();
    expect_out("expired_one_cycle_inc_ignored", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) tick();
    expect_out("alarm_after_9_ticks", 0, 0, 0, 0, 1, 0);
    tick();
    expect_out("alarm_end_10_ticks", 0, 0, 0, 0, 0, 0);

    // Pause with start/tick collision.
    inc_min();
    inc_min();
    start();
    for (int i = 0; i < 5; i++) tick();
    expect_out("run_5_ticks", 0, 1, 55, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 1);
    expect_out("pause_drops_tick", 0, 1, 55, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    expect_out("pause_frozen", 0, 1, 55, 0, 0, 0);
    inc_min();
    expect_out("pause_inc_min", 0, 2, 55, 0, 0, 0);
    start();
    expect_out("resume", 0, 2, 55, 1, 0, 0);
    tick();
    expect_out("resume_tick", 0, 2, 54, 1, 0, 0);
    inc_hr();
    expect_out("run_inc_ignored", 0, 2, 54, 1, 0, 0);

    // Second expiry acknowledged after 3 alarm ticks.
    clear();
    inc_min();
    start();
    for (int i = 0; i < 60; i++) tick();
    expect_out("expiry_2", 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick();
    expect_out("alarm_3_ticks", 0, 0, 0, 0, 1, 0);
    start();
    expect_out("alarm_ack", 0, 0, 0, 0, 0, 0);
    start();
    expect_out("ack_then_start_idle", 0, 0, 0, 0, 0, 0);

    // Clear beats start and tick.
    inc_min();
    start();
    for (int i = 0; i < 55; i++) tick();
    expect_out("run_5_left", 0, 0, 5, 1, 0, 0);
    drive(1, 1, 1, 0, 0, 1);
    expect_out("clear_priority", 0, 0, 0, 0, 0, 0);

    // Reset mid-run.
    for (int i = 0; i < 10; i++) inc_min();
    start();
    expect_out("run_10m", 0, 10, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    expect_out("reset_mid_run", 0, 0, 0, 0, 0, 0);

    idle();
    idle();
    @(negedge clk);
    if (sb_q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb_q.size());
      checks += sb_q.size();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Countdown-timer controller that sequences the hh:mm:ss counter datapath of the timer.
- Accepts debounced, synchronized single-cycle user button pulses and a 1 Hz tick.
- Owns set / run / pause / alarm sequencing: loads a time, decrements it once per tick, and raises an alarm on expiry for a bounded period.
- Sits between the button front-end and the display/alarm drivers.

Parameters:
- ALARM_SECS, 10, alarm duration in ticks; legal range 1..63.
- HOUR_MAX, 23, highest settable hour; legal range 1..31.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- tick_1hz  input  1  one-clk-cycle pulse, once per second
- btn_start  input  1  pulse; start / pause / resume / alarm acknowledge
- btn_clear  input  1  pulse; abort and zero the time
- btn_inc_min  input  1  pulse; minute +1 while setting
- btn_inc_hour  input  1  pulse; hour +1 while setting
- r_hour  output  5  remaining hours
- r_minute  output  6  remaining minutes
- r_second  output  6  remaining seconds
- running  output  1  high in RUN
- alarm  output  1  high in ALARM
- expired  output  1  one-cycle pulse on entry to ALARM

Behaviour:
- All outputs are registered and update on the clk edge following the causing input; one-cycle latency.
- Reset (rst_n=0 at a clk edge, in any state, including mid-run or mid-alarm):
  - state=IDLE; r_hour, r_minute, r_second = 0.
  - running=0, alarm=0, expired=0; alarm counter = 0.
- States: IDLE, RUN, PAUSE, ALARM. Encoding is free.
- Per-cycle input priority: btn_clear > btn_start > btn_inc_hour/btn_inc_min > tick_1hz. Lower-priority inputs in the same cycle are ignored, except that btn_inc_hour and btn_inc_min together both apply.
- IDLE:
  - btn_inc_min: r_minute +1, wraps 59->0, no carry into hours, r_second unchanged.
  - btn_inc_hour: r_hour +1, wraps HOUR_MAX->0.
  - btn_start with time nonzero: -> RUN. btn_start with time 00:00:00: ignored, stays IDLE.
  - btn_clear: time := 0.
  - Ticks are ignored.
- RUN:
  - On tick: decrement hh:mm:ss as one value. Seconds 0 borrows (s:=59, m-1); minutes 0 borrows (m:=59, h-1).
  - A tick that makes the value 00:00:00 -> ALARM. In that same update, time reads 0, alarm=1, expired=1, and the alarm counter loads ALARM_SECS.
  - btn_start: -> PAUSE; a simultaneous tick is dropped.
  - btn_clear: -> IDLE with time := 0.
  - Inc buttons are ignored.
- PAUSE:
  - Time is frozen; ticks are ignored.
  - Inc buttons behave as in IDLE.
  - btn_start: -> RUN if time nonzero, else -> IDLE.
  - btn_clear: -> IDLE with time := 0.
- ALARM:
  - Time stays 00:00:00.
  - Each tick decrements the alarm counter. The tick that brings it to 0 -> IDLE with alarm=0. Alarm is therefore high for exactly ALARM_SECS ticks.
  - btn_start or btn_clear: -> IDLE immediately, alarm=0.
  - Inc buttons are ignored.
- running = (state==RUN); alarm = (state==ALARM). expired is high for exactly one cycle per expiry, and never on reset or clear.
- Time registers never hold out-of-range values: second ≤ 59, minute ≤ 59, hour ≤ HOUR_MAX.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles while tick_1hz toggles -> time 00:00:00, running=0, alarm=0. btn_start alone -> stays IDLE.
- Set and wrap: 61 btn_inc_min pulses, then 25 btn_inc_hour pulses (HOUR_MAX=23) -> r_minute=1, r_hour=1, r_second=0.
- Borrow chain: set 01:00:00, btn_start, 1 tick -> 00:59:59. 3599 more ticks -> on the final tick 00:00:00, alarm=1, expired high for 1 cycle.
- Pause with collision: set 00:02:00, start, 5 ticks -> 00:01:55. btn_start and tick in the same cycle -> PAUSE at 00:01:55. 3 ticks -> unchanged. btn_inc_min -> 00:02:55. btn_start, 1 tick -> 00:02:54.
- Alarm duration and acknowledge: expire with ALARM_SECS=10 -> alarm high for exactly 10 ticks, then IDLE. Repeat expiry and press btn_start after 3 ticks -> alarm=0 next cycle, state IDLE.
- Clear/reset priority: in RUN at 00:00:05, assert btn_clear, btn_start and tick together -> IDLE, 00:00:00, expired=0. In RUN at 00:10:00, pulse rst_n=0 -> all outputs 0 next cycle.
